// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags and branch checkpoints.
// Snapshots of busy/tag are restored on mispredict without a flush.
`ifndef ROB_BIT
`define ROB_BIT 4
`endif

module rename_reg_file #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int RBIT    = $clog2(NREG),
    parameter int ROB_BIT = `ROB_BIT,
    parameter int RP      = 2,
    parameter int NCKPT   = 4,
    parameter int CBIT    = $clog2(NCKPT)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  commit_valid,
    input  logic [RBIT-1:0]       commit_reg,
    input  logic [XLEN-1:0]       commit_data,
    input  logic [ROB_BIT-1:0]    commit_tag,
    input  logic                  issue_valid,
    input  logic [RBIT-1:0]       issue_reg,
    input  logic [ROB_BIT-1:0]    issue_tag,
    input  logic [RP*RBIT-1:0]    rd_id,
    output logic [RP*XLEN-1:0]    rd_val,
    output logic [RP-1:0]         rd_has_dep,
    output logic [RP*ROB_BIT-1:0] rd_dep,
    output logic [RP*ROB_BIT-1:0] rob_q_tag,
    input  logic [RP-1:0]         rob_q_ready,
    input  logic [RP*XLEN-1:0]    rob_q_value,
    input  logic                  ckpt_save,
    output logic [CBIT-1:0]       ckpt_save_id,
    output logic                  ckpt_full,
    input  logic                  ckpt_restore,
    input  logic [CBIT-1:0]       ckpt_restore_id,
    input  logic                  ckpt_free,
    input  logic [CBIT-1:0]       ckpt_free_id
);

    typedef logic [NREG-1:0][ROB_BIT-1:0] tagv_t;

    logic [XLEN-1:0]  r_regs      [NREG];
    logic [NREG-1:0]  r_busy;
    tagv_t            r_tag;
    logic [NREG-1:0]  r_snap_busy [NCKPT];
    tagv_t            r_snap_tag  [NCKPT];
    logic [NCKPT-1:0] r_slot_used;

    logic             w_commit_en;
    logic             w_issue_en;
    logic             w_restore_ok;
    logic             w_save_ok;
    logic [NREG-1:0]  w_busy_upd;
    tagv_t            w_tag_upd;
    logic [NREG-1:0]  w_busy_rst;
    tagv_t            w_tag_rst;
    logic [NCKPT-1:0] w_used_nx;
    logic [CBIT-1:0]  w_save_id;
    logic [RBIT-1:0]  w_rid;

    assign w_commit_en  = commit_valid && (commit_reg != '0);
    assign w_issue_en   = issue_valid && (issue_reg != '0);
    assign w_restore_ok = ckpt_restore && r_slot_used[ckpt_restore_id];
    assign w_save_ok    = ckpt_save && !ckpt_full && !ckpt_restore;
    assign ckpt_full    = &r_slot_used;
    assign ckpt_save_id = w_save_id;

    // Lowest free checkpoint slot
    always_comb begin
        w_save_id = '0;
        for (int s = NCKPT - 1; s >= 0; s--) begin
            if (!r_slot_used[s]) w_save_id = CBIT'(s);
        end
    end

    // Operand lookup with commit bypass and ROB forwarding
    always_comb begin
        rd_val     = '0;
        rd_has_dep = '0;
        rd_dep     = '0;
        rob_q_tag  = '0;
        w_rid      = '0;
        for (int k = 0; k < RP; k++) begin
            w_rid = rd_id[k*RBIT +: RBIT];
            rob_q_tag[k*ROB_BIT +: ROB_BIT] = r_tag[w_rid];
            rd_dep[k*ROB_BIT +: ROB_BIT]    = r_tag[w_rid];
            rd_val[k*XLEN +: XLEN]          = r_regs[w_rid];
            if (w_rid == '0) begin
                rd_val[k*XLEN +: XLEN] = '0;
            end else if (!r_busy[w_rid]) begin
                rd_val[k*XLEN +: XLEN] = r_regs[w_rid];
            end else if (commit_valid && commit_tag == r_tag[w_rid]) begin
                rd_val[k*XLEN +: XLEN] = commit_data;
            end else if (rob_q_ready[k]) begin
                rd_val[k*XLEN +: XLEN] = rob_q_value[k*XLEN +: XLEN];
            end else begin
                rd_has_dep[k] = 1'b1;
            end
        end
    end

    // Next rename table: live path (commit then issue) and restore path
    always_comb begin
        w_busy_upd = r_busy;
        w_tag_upd  = r_tag;
        if (w_commit_en && r_busy[commit_reg] &&
            r_tag[commit_reg] == commit_tag)
            w_busy_upd[commit_reg] = 1'b0;
        if (w_issue_en) begin
            w_busy_upd[issue_reg] = 1'b1;
            w_tag_upd[issue_reg]  = issue_tag;
        end
        w_busy_rst = r_snap_busy[ckpt_restore_id];
        w_tag_rst  = r_snap_tag[ckpt_restore_id];
        if (w_commit_en && w_tag_rst[commit_reg] == commit_tag)
            w_busy_rst[commit_reg] = 1'b0;
        w_used_nx = r_slot_used;
        if (ckpt_free) w_used_nx[ckpt_free_id] = 1'b0;
        if (w_restore_ok) w_used_nx[ckpt_restore_id] = 1'b0;
        if (w_save_ok) w_used_nx[w_save_id] = 1'b1;
    end

    // State update: reset, hold, flush, then normal cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_busy      <= '0;
            r_tag       <= '0;
            r_slot_used <= '0;
        end else if (rdy_in) begin
            if (w_commit_en) r_regs[commit_reg] <= commit_data;
            if (flush_in) begin
                r_busy      <= '0;
                r_tag       <= '0;
                r_slot_used <= '0;
            end else begin
                if (w_restore_ok) begin
                    r_busy <= w_busy_rst;
                    r_tag  <= w_tag_rst;
                end else begin
                    r_busy <= w_busy_upd;
                    r_tag  <= w_tag_upd;
                end
                for (int s = 0; s < NCKPT; s++) begin
                    if (w_commit_en && r_slot_used[s] &&
                        r_snap_tag[s][commit_reg] == commit_tag)
                        r_snap_busy[s][commit_reg] <= 1'b0;
                end
                if (w_save_ok) begin
                    r_snap_busy[w_save_id] <= w_busy_upd;
                    r_snap_tag[w_save_id]  <= w_tag_upd;
                end
                r_slot_used <= w_used_nx;
            end
        end
    end

    // Restoring a slot that holds no snapshot is a controller bug
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush_in && ckpt_restore)
            assert (r_slot_used[ckpt_restore_id])
            else $fatal(1, "restore of unused checkpoint slot");
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file.
// Expected values are hand-computed per vector.
module tb_rename_reg_file;

    localparam int XLEN = 32;
    localparam int RBIT = 5;
    localparam int RB   = 4;
    localparam int RP   = 2;
    localparam int CB   = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              flush_in;
    logic              commit_valid;
    logic [RBIT-1:0]   commit_reg;
    logic [XLEN-1:0]   commit_data;
    logic [RB-1:0]     commit_tag;
    logic              issue_valid;
    logic [RBIT-1:0]   issue_reg;
    logic [RB-1:0]     issue_tag;
    logic [RP*RBIT-1:0] rd_id;
    logic [RP*XLEN-1:0] rd_val;
    logic [RP-1:0]     rd_has_dep;
    logic [RP*RB-1:0]  rd_dep;
    logic [RP*RB-1:0]  rob_q_tag;
    logic [RP-1:0]     rob_q_ready;
    logic [RP*XLEN-1:0] rob_q_value;
    logic              ckpt_save;
    logic [CB-1:0]     ckpt_save_id;
    logic              ckpt_full;
    logic              ckpt_restore;
    logic [CB-1:0]     ckpt_restore_id;
    logic              ckpt_free;
    logic [CB-1:0]     ckpt_free_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    rename_reg_file #(
        .XLEN(XLEN), .NREG(32), .ROB_BIT(RB),
        .RP(RP), .NCKPT(4)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .flush_in(flush_in),
        .commit_valid(commit_valid), .commit_reg(commit_reg),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .issue_tag(issue_tag),
        .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep),
        .rd_dep(rd_dep), .rob_q_tag(rob_q_tag),
        .rob_q_ready(rob_q_ready), .rob_q_value(rob_q_value),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
        .ckpt_full(ckpt_full), .ckpt_restore(ckpt_restore),
        .ckpt_restore_id(ckpt_restore_id), .ckpt_free(ckpt_free),
        .ckpt_free_id(ckpt_free_id)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        flush_in = 0; commit_valid = 0; issue_valid = 0;
        ckpt_save = 0; ckpt_restore = 0; ckpt_free = 0;
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r0);
        rd_id = {r1, r0};
        #1;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] t,
                          input logic [31:0] d);
        commit_valid = 1; commit_reg = r; commit_tag = t; commit_data = d;
    endtask

    task automatic issue(input logic [4:0] r, input logic [3:0] t);
        issue_valid = 1; issue_reg = r; issue_tag = t;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; idle();
        commit_reg = 0; commit_data = 0; commit_tag = 0;
        issue_reg = 0; issue_tag = 0; rd_id = 0;
        rob_q_ready = 0; rob_q_value = 0;
        ckpt_restore_id = 0; ckpt_free_id = 0;
        tick(); tick();
        rst_in = 0;

        rd(5, 5);
        check("rst_val0", rd_val[31:0], 0);
        check("rst_val1", rd_val[63:32], 0);
        check("rst_dep", rd_has_dep, 0);
        check("rst_full", ckpt_full, 0);
        check("rst_sid", ckpt_save_id, 0);

        issue(3, 7); tick(); idle();
        rd(3, 3);
        check("x3_dep", rd_has_dep, 2'b11);
        check("x3_tag", rd_dep[3:0], 7);
        check("x3_qtag", rob_q_tag[7:4], 7);
        rob_q_ready = 2'b01; rob_q_value = {32'h0, 32'h55}; #1;
        check("x3_rob_val", rd_val[31:0], 32'h55);
        check("x3_rob_dep", rd_has_dep, 2'b10);
        rob_q_ready = 0;

        commit(3, 7, 32'hAB); #1;
        check("x3_byp_val", rd_val[63:32], 32'hAB);
        check("x3_byp_dep", rd_has_dep, 2'b00);
        tick(); idle(); #1;
        check("x3_com_dep", rd_has_dep, 2'b00);
        check("x3_com_val", rd_val[63:32], 32'hAB);

        commit(4, 2, 32'h44); issue(4, 9); tick(); idle();
        rd(4, 4);
        check("x4_dep", rd_has_dep, 2'b11);
        check("x4_tag", rd_dep[3:0], 9);
        check("x4_reg", rd_val[31:0], 32'h44);

        issue(8, 5); rd(0, 8);
        check("x8_preissue", rd_has_dep, 2'b00);
        tick(); idle();

        issue(6, 1); tick(); idle();
        check("sid0", ckpt_save_id, 0);
        ckpt_save = 1; tick(); idle();
        check("sid1", ckpt_save_id, 1);
        issue(6, 4); tick(); idle();
        commit(6, 1, 32'h66); tick(); idle();
        rd(0, 6);
        check("x6_live_tag", rd_dep[3:0], 4);
        ckpt_restore = 1; ckpt_restore_id = 0;
        commit(8, 5, 32'h88); issue(9, 3);
        tick(); idle();
        rd(8, 6);
        check("rs_x6_dep", rd_has_dep[0], 0);
        check("rs_x6_val", rd_val[31:0], 32'h66);
        check("rs_x8_dep", rd_has_dep[1], 0);
        check("rs_x8_val", rd_val[63:32], 32'h88);
        rd(9, 4);
        check("rs_x4_dep", rd_has_dep[0], 1);
        check("rs_x4_tag", rd_dep[3:0], 9);
        check("rs_x9_dep", rd_has_dep[1], 0);
        check("rs_sid", ckpt_save_id, 0);
        check("rs_full", ckpt_full, 0);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_sid%0d", i), ckpt_save_id, i);
            ckpt_save = 1; tick(); idle();
        end
        check("full", ckpt_full, 1);
        ckpt_save = 1; tick(); idle();
        check("full_drop", ckpt_full, 1);
        ckpt_free = 1; ckpt_free_id = 2; tick(); idle();
        check("free_sid", ckpt_save_id, 2);
        check("free_full", ckpt_full, 0);
        ckpt_save = 1; ckpt_free = 1; ckpt_free_id = 2;
        tick(); idle();
        check("save_wins", ckpt_full, 1);

        rdy_in = 0; issue(10, 6); ckpt_free = 1; ckpt_free_id = 0;
        tick(); idle(); rdy_in = 1;
        rd(0, 10);
        check("hold_x10", rd_has_dep[0], 0);
        check("hold_full", ckpt_full, 1);

        flush_in = 1; commit(4, 9, 32'h99); issue(11, 2);
        tick(); idle();
        rd(11, 4);
        check("fl_full", ckpt_full, 0);
        check("fl_sid", ckpt_save_id, 0);
        check("fl_dep", rd_has_dep, 2'b00);
        check("fl_x4_val", rd_val[31:0], 32'h99);

        commit(0, 1, 32'hFF); issue(0, 1); tick(); idle();
        rob_q_ready = 2'b11; rob_q_value = {32'h12, 32'h34};
        rd(0, 0);
        check("x0_val", rd_val, 0);
        check("x0_dep", rd_has_dep, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural register file with per-register rename tags (busy bit + ROB entry) and a parametrised number of source read ports.
- Adds branch checkpoints: snapshots of the rename table, restored on a mispredict without a full flush.
- Sits between decoder/issue, ROB commit and ROB value query.
- Supersedes the fixed two-port, flush-only register file.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count. Register 0 is hardwired to zero.
- RBIT, $clog2(NREG), register index width.
- ROB_BIT, `ROB_BIT, ROB tag width.
- RP, 2, number of read ports.
- NCKPT, 4, checkpoint slot count.
- CBIT, $clog2(NCKPT), checkpoint id width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset. Synchronous, active-high.
- rdy_in  in  1  low = hold all state.
- flush_in  in  1  ROB clear-up.
- commit_valid  in  1  ROB commit strobe.
- commit_reg  in  RBIT  committed destination register.
- commit_data  in  XLEN  committed value.
- commit_tag  in  ROB_BIT  committed ROB entry.
- issue_valid  in  1  issue of an instruction with a destination.
- issue_reg  in  RBIT  destination register.
- issue_tag  in  ROB_BIT  ROB entry allocated to the instruction.
- rd_id  in  RP*RBIT  source register per port. Port k occupies bits [k*RBIT +: RBIT].
- rd_val  out  RP*XLEN  operand value per port.
- rd_has_dep  out  RP  operand not yet available.
- rd_dep  out  RP*ROB_BIT  ROB tag to wait on.
- rob_q_tag  out  RP*ROB_BIT  tag queried from the ROB.
- rob_q_ready  in  RP  ROB entry has a result.
- rob_q_value  in  RP*XLEN  that result.
- ckpt_save  in  1  take a snapshot.
- ckpt_save_id  out  CBIT  slot the next save uses. Lowest free index.
- ckpt_full  out  1  no free slot.
- ckpt_restore  in  1  restore a snapshot.
- ckpt_restore_id  in  CBIT  slot to restore.
- ckpt_free  in  1  release a slot (branch resolved correctly).
- ckpt_free_id  in  CBIT  slot to release.

Behaviour:
State:
- regs[NREG], busy[NREG], tag[NREG].
- Per slot: snap_busy[NREG], snap_tag[NREG], slot_used.

Read ports (combinational, all ports identical and independent). For port k, with r = rd_id[k]:
- rob_q_tag = tag[r].
- r == 0: rd_val = 0, rd_has_dep = 0.
- Else if !busy[r]: rd_val = regs[r], rd_has_dep = 0.
- Else if commit_valid && commit_tag == tag[r]: rd_val = commit_data, rd_has_dep = 0 (commit bypass).
- Else if rob_q_ready: rd_val = rob_q_value, rd_has_dep = 0.
- Else: rd_has_dep = 1, rd_dep = tag[r], rd_val = don't-care (drive regs[r]).
- Reads see the pre-issue table: a same-cycle issue never affects its own sources.

Sequential update, in priority order:
1. rst_in: all regs, busy, tag and slot_used cleared. Outputs after reset: rd_val = 0, rd_has_dep = 0, ckpt_full = 0, ckpt_save_id = 0.
2. !rdy_in: hold everything.
3. flush_in:
   - busy and tag cleared, all slot_used cleared.
   - regs still take a same-cycle commit.
   - issue, save, restore and free are ignored.
4. Normal cycle:
   - Commit (commit_valid && commit_reg != 0): regs[commit_reg] <= commit_data.
   - If busy[commit_reg] && tag[commit_reg] == commit_tag, clear busy, unless the same-cycle issue targets that register; issue wins.
   - Commit also clears snap_busy[commit_reg] in every used slot whose snap_tag matches. This prevents stale dependencies after a restore.
   - Issue (issue_valid && issue_reg != 0): busy <= 1, tag <= issue_tag.
   - Save (ckpt_save && !ckpt_full && !ckpt_restore): slot ckpt_save_id copies busy/tag as updated by this cycle's commit and issue, and becomes used.
   - Save while full is dropped; the issue logic must stall on ckpt_full.
   - Restore (ckpt_restore, slot used):
     - busy/tag <= snapshot, then this cycle's commit clear is applied.
     - This cycle's issue is ignored.
     - The restored slot is freed. Younger slots are released by the controller via ckpt_free.
   - Restore of an unused slot is a no-op (simulation $fatal).
   - Free: clears slot_used. Free and save on the same slot in one cycle: save wins.
- ckpt_full = all slot_used set. ckpt_save_id = lowest clear index. Both are combinational from registered state.
- Writes to register 0 never change any state.

Test Plan:
- Reset, then read x5 on both ports -> rd_val = 0, rd_has_dep = 0, ckpt_full = 0.
- Issue x3 tag 7; next cycle read x3 with rob_q_ready = 0 -> rd_has_dep = 1, rd_dep = 7, rob_q_tag = 7. Set rob_q_ready = 1, value 0x55 -> rd_val = 0x55, dep = 0.
- Commit x3 tag 7 data 0xAB while port 1 reads x3 -> same cycle rd_val = 0xAB, dep = 0. Next cycle busy clear, regs[3] = 0xAB.
- Same cycle: commit x4 tag 2 and issue x4 tag 9 -> x4 busy with tag 9, regs[4] = commit data.
- Issue x6 tag 1; save (id 0); issue x6 tag 4; commit tag 1; restore 0 -> x6 not busy, regs[6] = committed value, slot 0 free.
- Save NCKPT times -> ckpt_full = 1, extra save dropped. Free slot 2 -> ckpt_save_id = 2. Flush -> all slots free, no register busy.
